ram_port_arbiter: RTL

//  Sits directly upstream of the single-port, read-latency-1 word RAM (RAM_32x2048 class) in the CPU testbench.

---
 rtl/ram_port_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Shares one read-latency-1 word RAM between instruction fetch and data load/store ports.
// Data has fixed priority; partial stores take a two-cycle read-modify-write through RMW_MERGE.
module ram_port_arbiter #(
    parameter int          MEM_WORDS = 2048,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_ready_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_i,
    input  logic        data_write_i,
    input  logic [31:0] data_addr_i,
    input  logic [3:0]  data_byteenable_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_ready_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic [31:0] ram_address_o,
    output logic        ram_write_o,
    output logic        ram_read_o,
    output logic [31:0] ram_writedata_o,
    input  logic [31:0] ram_readdata_i
);

    typedef enum logic {
        IDLE      = 1'b0,
        RMW_MERGE = 1'b1
    } state_t;

    state_t      state_q, state_d;

    logic        instr_rvalid_q, instr_rvalid_d;
    logic        instr_ok_q, instr_ok_d;
    logic [31:0] instr_hold_q, instr_hold_d;
    logic        data_rvalid_q, data_rvalid_d;
    logic        data_ok_q, data_ok_d;
    logic [31:0] data_hold_q, data_hold_d;
    logic [31:0] rmw_idx_q, rmw_idx_d;
    logic [3:0]  rmw_be_q, rmw_be_d;
    logic [31:0] rmw_wdata_q, rmw_wdata_d;

    logic        instr_ready, data_ready, ram_read, ram_write;
    logic [31:0] ram_address, ram_writedata;
    logic [31:0] rmw_merged;
    logic [31:0] instr_rdata, data_rdata;

    // 33-bit difference: the top bit is the borrow, i.e. address below BASE_ADDR.
    logic [32:0] instr_diff, data_diff;
    logic [31:0] instr_idx, data_idx;
    logic        instr_in_range, data_in_range;

    assign instr_diff     = {1'b0, instr_addr_i} - {1'b0, BASE_ADDR};
    assign data_diff      = {1'b0, data_addr_i} - {1'b0, BASE_ADDR};
    assign instr_idx      = instr_diff[31:0] >> 2;
    assign data_idx       = data_diff[31:0] >> 2;
    assign instr_in_range = !instr_diff[32] && (instr_idx < 32'(MEM_WORDS));
    assign data_in_range  = !data_diff[32] && (data_idx < 32'(MEM_WORDS));

    always_comb begin
        rmw_merged = ram_readdata_i;
        for (int i = 0; i < 4; i++) begin
            if (rmw_be_q[i]) begin
                rmw_merged[8*i +: 8] = rmw_wdata_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        instr_ready    = 1'b0;
        data_ready     = 1'b0;
        ram_read       = 1'b0;
        ram_write      = 1'b0;
        ram_address    = 32'h0;
        ram_writedata  = 32'h0;
        instr_rvalid_d = 1'b0;
        instr_ok_d     = instr_ok_q;
        data_rvalid_d  = 1'b0;
        data_ok_d      = data_ok_q;
        rmw_idx_d      = rmw_idx_q;
        rmw_be_d       = rmw_be_q;
        rmw_wdata_d    = rmw_wdata_q;

        case (state_q)
            IDLE: begin
                if (data_req_i) begin
                    ram_address = data_in_range ? data_idx : 32'h0;
                    if (!data_write_i) begin
                        data_ready    = 1'b1;
                        ram_read      = 1'b1;
                        data_rvalid_d = 1'b1;
                        data_ok_d     = data_in_range;
                    end else if (!data_in_range || data_byteenable_i == 4'h0) begin
                        data_ready = 1'b1;
                    end else if (data_byteenable_i == 4'hF) begin
                        data_ready    = 1'b1;
                        ram_write     = 1'b1;
                        ram_writedata = data_wdata_i;
                    end else begin
                        // Partial store: fetch the old word now, merge and write next cycle.
                        ram_read    = 1'b1;
                        rmw_idx_d   = data_idx;
                        rmw_be_d    = data_byteenable_i;
                        rmw_wdata_d = data_wdata_i;
                        state_d     = RMW_MERGE;
                    end
                end else if (instr_req_i) begin
                    instr_ready    = 1'b1;
                    ram_read       = 1'b1;
                    ram_address    = instr_in_range ? instr_idx : 32'h0;
                    instr_rvalid_d = 1'b1;
                    instr_ok_d     = instr_in_range;
                end
            end
            RMW_MERGE: begin
                ram_write     = 1'b1;
                ram_address   = rmw_idx_q;
                ram_writedata = rmw_merged;
                data_ready    = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read data is presented straight from the RAM in the rvalid cycle and held afterwards.
    assign instr_rdata  = instr_ok_q ? ram_readdata_i : 32'h0;
    assign data_rdata   = data_ok_q ? ram_readdata_i : 32'h0;
    assign instr_hold_d = instr_rvalid_q ? instr_rdata : instr_hold_q;
    assign data_hold_d  = data_rvalid_q ? data_rdata : data_hold_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            instr_rvalid_q <= 1'b0;
            instr_ok_q     <= 1'b0;
            instr_hold_q   <= 32'h0;
            data_rvalid_q  <= 1'b0;
            data_ok_q      <= 1'b0;
            data_hold_q    <= 32'h0;
            rmw_idx_q      <= 32'h0;
            rmw_be_q       <= 4'h0;
            rmw_wdata_q    <= 32'h0;
        end else begin
            state_q        <= state_d;
            instr_rvalid_q <= instr_rvalid_d;
            instr_ok_q     <= instr_ok_d;
            instr_hold_q   <= instr_hold_d;
            data_rvalid_q  <= data_rvalid_d;
            data_ok_q      <= data_ok_d;
            data_hold_q    <= data_hold_d;
            rmw_idx_q      <= rmw_idx_d;
            rmw_be_q       <= rmw_be_d;
            rmw_wdata_q    <= rmw_wdata_d;
        end
    end

    // Reset must kill any RAM strobe immediately, including a half-finished merge.
    assign instr_ready_o   = instr_ready & ~reset_i;
    assign data_ready_o    = data_ready & ~reset_i;
    assign ram_read_o      = ram_read & ~reset_i;
    assign ram_write_o     = ram_write & ~reset_i;
    assign ram_address_o   = ram_address;
    assign ram_writedata_o = ram_writedata;

    assign instr_rvalid_o  = instr_rvalid_q;
    assign instr_rdata_o   = instr_rvalid_q ? instr_rdata : instr_hold_q;
    assign data_rvalid_o   = data_rvalid_q;
    assign data_rdata_o    = data_rvalid_q ? data_rdata : data_hold_q;

endmodule
